// File: rtl/gsim_residual_check.sv
// gsim_residual_check: snoops a GSIM b/x frame, recomputes the 16-row banded residual
// and reports the largest |r|, its first row, and a pass flag against TOL.
module gsim_residual_check #(
    parameter logic [31:0] TOL = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    input  logic        out_valid,
    input  logic [31:0] x_out,
    output logic        done,
    output logic        pass,
    output logic [31:0] max_abs,
    output logic [3:0]  worst_idx
);
    typedef enum logic [1:0] {LOAD_B, LOAD_X, CALC, REPORT} state_t;
    state_t             r_state;
    logic        [15:0] r_b [16];
    logic signed [31:0] r_x [16];
    logic        [3:0]  r_bi, r_xi, r_s1_idx, r_widx, r_worst;
    logic        [4:0]  r_ci;
    logic               r_s1_vld, r_done, r_pass;
    logic signed [38:0] r_res;
    logic        [38:0] r_max;
    logic        [31:0] r_max_abs;
    logic        [4:0]  w_n [7];
    logic signed [38:0] w_nb [7];
    logic signed [38:0] w_c1, w_c2, w_c3, w_lhs, w_res;
    logic        [38:0] w_abs;
    logic               w_abort, w_xwe;
    logic        [3:0]  w_bwa;
    // Neighbour index wraps above 15 when out of range, so bit 4 flags a zero tap.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_n[k]  = 5'(r_ci[3:0]) + 5'(k) - 5'd3;
            w_nb[k] = w_n[k][4] ? '0 : 39'(r_x[w_n[k][3:0]]);
        end
    end
    assign w_c1  = w_nb[2] + w_nb[4];
    assign w_c2  = w_nb[1] + w_nb[5];
    assign w_c3  = w_nb[0] + w_nb[6];
    assign w_lhs = (w_nb[3] <<< 4) + (w_nb[3] <<< 2) - ((w_c1 <<< 3) + (w_c1 <<< 2) + w_c1)
                 + (w_c2 <<< 2) + (w_c2 <<< 1) - w_c3;
    assign w_res = {{7{r_b[r_ci[3:0]][15]}}, r_b[r_ci[3:0]], 16'd0} - w_lhs;
    assign w_abs = r_res[38] ? -r_res : r_res;
    assign w_abort = in_en && r_state != LOAD_B;
    assign w_xwe   = out_valid && !in_en && r_state == LOAD_X;
    assign w_bwa   = w_abort ? 4'd0 : r_bi;
    always_ff @(posedge clk) begin
        if (in_en) r_b[w_bwa] <= b_in;
        if (w_xwe) r_x[r_xi] <= x_out;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= LOAD_B;
            r_bi      <= '0;
            r_xi      <= '0;
            r_ci      <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= '0;
            r_res     <= '0;
            r_max     <= '0;
            r_widx    <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_max_abs <= '0;
            r_worst   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_s1_vld <= r_state == CALC && !r_ci[4];
            r_s1_idx <= r_ci[3:0];
            r_res    <= w_res;
            if (r_state == CALC && !r_ci[4]) r_ci <= r_ci + 5'd1;
            if (r_s1_vld && w_abs > r_max) begin
                r_max  <= w_abs;
                r_widx <= r_s1_idx;
            end
            if (w_abort) begin
                r_state <= LOAD_B;
                r_bi    <= 4'd1;
                r_xi    <= 4'd0;
            end else if (r_state == LOAD_B) begin
                if (in_en) begin
                    r_bi <= r_bi + 4'd1;
                    if (r_bi == 4'd15) r_state <= LOAD_X;
                end
            end else if (r_state == LOAD_X) begin
                if (out_valid) begin
                    r_xi <= r_xi + 4'd1;
                    if (r_xi == 4'd15) begin
                        r_state <= CALC;
                        r_ci    <= '0;
                        r_max   <= '0;
                        r_widx  <= '0;
                    end
                end
            end else if (r_state == CALC) begin
                if (r_s1_vld && r_s1_idx == 4'd15) r_state <= REPORT;
            end else begin
                r_max_abs <= |r_max[38:31] ? 32'h7FFF_FFFF : r_max[31:0];
                r_worst   <= r_widx;
                r_pass    <= r_max <= {7'd0, TOL};
                r_done    <= 1'b1;
                r_state   <= LOAD_B;
                r_bi      <= 4'd0;
                r_xi      <= 4'd0;
            end
        end
    end
    assign done      = r_done;
    assign pass      = r_pass;
    assign max_abs   = r_max_abs;
    assign worst_idx = r_worst;
endmodule

// File: tb/tb_gsim_residual_check.sv
// tb_gsim_residual_check: directed and randomized frames against a plain-arithmetic residual model.
module tb_gsim_residual_check;
    localparam longint TOL = 64'h400;
    logic        clk = 1'b0, reset = 1'b0, in_en = 1'b0, out_valid = 1'b0;
    logic [15:0] b_in = '0;
    logic [31:0] x_out = '0;
    logic        done, pass;
    logic [31:0] max_abs;
    logic [3:0]  worst_idx;
    int bv [16];
    int xv [16];
    int n_chk = 0, n_err = 0, n_done = 0, exp_done = 0;
    bit pend = 1'b0;

    gsim_residual_check dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .out_valid(out_valid),
        .x_out(x_out), .done(done), .pass(pass), .max_abs(max_abs), .worst_idx(worst_idx)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(output longint mx, output longint idx, output longint ps);
        longint lhs, r, a;
        int c [7] = '{-1, 6, -13, 20, -13, 6, -1};
        mx = 0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            lhs = 0;
            for (int d = 0; d < 7; d++)
                if (i + d - 3 >= 0 && i + d - 3 < 16) lhs += longint'(c[d]) * longint'(xv[i + d - 3]);
            r = longint'(bv[i]) * 65536 - lhs;
            a = r < 0 ? -r : r;
            if (a > mx) begin
                mx = a;
                idx = i;
            end
        end
        ps = mx <= TOL ? 1 : 0;
        if (mx > 64'h7FFF_FFFF) mx = 64'h7FFF_FFFF;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            bv[i] = 0;
            xv[i] = 0;
        end
    endtask

    // x = integer solution k plus small noise; b = A*k exactly, so residual = -A*noise
    task automatic valid_frame(input int amp, input int noise);
        int k [16];
        int c [7] = '{-1, 6, -13, 20, -13, 6, -1};
        for (int i = 0; i < 16; i++) k[i] = int'($urandom_range(0, 2 * amp)) - amp;
        for (int i = 0; i < 16; i++) begin
            bv[i] = 0;
            for (int d = 0; d < 7; d++)
                if (i + d - 3 >= 0 && i + d - 3 < 16) bv[i] += c[d] * k[i + d - 3];
            xv[i] = k[i] * 65536 + int'($urandom_range(0, 2 * noise)) - noise;
        end
    endtask

    task automatic raw_frame();
        for (int i = 0; i < 16; i++) begin
            bv[i] = int'($urandom_range(0, 65535)) - 32768;
            xv[i] = int'($urandom);
        end
    endtask

    task automatic run_frame(input int gap, input int nx, input bit ov0, input bit wait_done);
        int got;
        longint mx, idx, ps;
        for (int i = 0; i < 16; i++) begin
            in_en = 1'b1;
            b_in = bv[i][15:0];
            out_valid = (i == 0) && ov0;
            x_out = $urandom;
            @(negedge clk);
            if (i == 0 && pend) begin
                check("done_pulse", done, 0);
                pend = 1'b0;
            end
        end
        in_en = 1'b0;
        out_valid = 1'b0;
        for (int i = 0; i < nx; i++) begin
            if (gap == 1 && i > 0) repeat (2) @(negedge clk);
            else if (gap == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
            out_valid = 1'b1;
            x_out = xv[i];
            @(negedge clk);
            out_valid = 1'b0;
        end
        if (nx == 16 && wait_done) begin
            got = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) begin
                    got = k;
                    break;
                end
            end
            check("latency", got, 18);
            model(mx, idx, ps);
            check("max_abs", max_abs, mx);
            check("worst_idx", worst_idx, idx);
            check("pass", pass, ps);
            pend = 1'b1;
            exp_done++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        out_valid = 1'b1;
        x_out = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_max", max_abs, 0);
        check("rst_idx", worst_idx, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        out_valid = 1'b0;
        clear_frame();
        run_frame(0, 16, 0, 1);
        clear_frame();
        xv[0] = 32'h0001_0000;
        run_frame(0, 16, 0, 1);
        clear_frame();
        bv[5] = 1;
        run_frame(0, 16, 0, 1);
        clear_frame();
        bv[3] = 2;
        bv[9] = 2;
        run_frame(0, 16, 0, 1);
        valid_frame(100, 8);
        run_frame(1, 16, 0, 1);
        valid_frame(50, 4);
        run_frame(0, 7, 0, 0);
        valid_frame(80, 6);
        run_frame(0, 16, 1, 1);
        clear_frame();
        xv[7] = 1;
        run_frame(0, 16, 0, 1);
        raw_frame();
        run_frame(0, 16, 0, 0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_max", max_abs, 0);
        check("mid_rst_idx", worst_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        pend = 1'b0;
        valid_frame(60, 8);
        run_frame(2, 16, 0, 1);
        for (int f = 0; f < 24; f++) begin
            if (f % 3 == 2) raw_frame();
            else valid_frame(int'($urandom_range(1, 300)), int'($urandom_range(0, 40)));
            run_frame(int'($urandom_range(0, 2)), 16, 0, 1);
        end
        repeat (3) @(negedge clk);
        check("done_count", n_done, exp_done);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
